// File: rtl/traffic_light_controller.sv
// Two-road intersection lamp controller: main road A, side road B.
// Registered Moore outputs; amber timing comes from an external timer.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   traffic_B   vehicle present/waiting on road B
//   timer_done  external interval timer expired (level)
//   traffic_out {A_red, A_amber, A_green, B_red, B_amber, B_green, timer_start}
module traffic_light_controller (
    input  logic       clk,
    input  logic       rstn,
    input  logic       traffic_B,
    input  logic       timer_done,
    output logic [6:0] traffic_out
);

    typedef enum logic [1:0] {
        GARB = 2'b00,
        AARB = 2'b01,
        RAGB = 2'b10,
        RAAB = 2'b11
    } state_t;

    localparam logic [6:0] OUT_GARB = 7'h18;
    localparam logic [6:0] OUT_AARB = 7'h28;
    localparam logic [6:0] OUT_RAGB = 7'h42;
    localparam logic [6:0] OUT_RAAB = 7'h44;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] out_q;
    logic [6:0] out_d;
    logic       entry_q;

    // timer_start is high exactly in the first amber cycle; a done seen
    // then is stale from the previous interval and must not end amber.
    assign entry_q = out_q[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= GARB;
            out_q   <= OUT_GARB;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = OUT_GARB;

        case (state_q)
            GARB: begin
                if (traffic_B) begin
                    state_d = AARB;
                end
            end
            AARB: begin
                if (timer_done && !entry_q) begin
                    state_d = RAGB;
                end
            end
            RAGB: begin
                if (!traffic_B) begin
                    state_d = RAAB;
                end
            end
            RAAB: begin
                if (timer_done && !entry_q) begin
                    state_d = GARB;
                end
            end
            default: begin
                state_d = GARB;
            end
        endcase

        case (state_d)
            GARB:    out_d = OUT_GARB;
            AARB:    out_d = OUT_AARB;
            RAGB:    out_d = OUT_RAGB;
            RAAB:    out_d = OUT_RAAB;
            default: out_d = OUT_GARB;
        endcase

        // Request a new timer interval on entry to either amber phase.
        if ((state_d == AARB || state_d == RAAB) && state_d != state_q) begin
            out_d[0] = 1'b1;
        end
    end

    assign traffic_out = out_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller.
// Directed test-plan sequence followed by randomized traffic/timer stimulus.
module tb_traffic_light_controller;

    logic       clk;
    logic       rstn;
    logic       traffic_B;
    logic       timer_done;
    logic [6:0] traffic_out;

    int n_chk;
    int n_pass;

    // Reference model: phase index 0..3 (A green, A amber, B green,
    // B amber) and number of cycles already spent in that phase.
    int         m_phase;
    int         m_age;
    logic [6:0] lamp_tbl [4];

    traffic_light_controller dut (
        .clk         (clk),
        .rstn        (rstn),
        .traffic_B   (traffic_B),
        .timer_done  (timer_done),
        .traffic_out (traffic_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got,
                         input logic [6:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [6:0] v;
        v = lamp_tbl[m_phase];
        if ((m_phase == 1 || m_phase == 3) && m_age == 0) v[0] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic tb_in,
                              input logic td);
        int nxt;
        nxt = m_phase;
        if (!r) begin
            nxt = 0;
        end else begin
            case (m_phase)
                0: if (tb_in) nxt = 1;
                1: if (td && m_age > 0) nxt = 2;
                2: if (!tb_in) nxt = 3;
                default: if (td && m_age > 0) nxt = 0;
            endcase
        end
        if (!r || nxt != m_phase) m_age = 0;
        else m_age++;
        m_phase = nxt;
    endtask

    task automatic step(input logic r, input logic tb_in, input logic td);
        rstn       = r;
        traffic_B  = tb_in;
        timer_done = td;
        @(posedge clk);
        model_edge(r, tb_in, td);
        #1;
    endtask

    // Directed step: check against the test-plan value and the model.
    task automatic dstep(input string tag, input logic r, input logic tb_in,
                         input logic td, input logic [6:0] exp);
        step(r, tb_in, td);
        check(tag, traffic_out, exp);
        check({tag, "_model"}, traffic_out, model_out());
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        m_phase    = 0;
        m_age      = 0;
        lamp_tbl[0] = 7'h18;
        lamp_tbl[1] = 7'h28;
        lamp_tbl[2] = 7'h42;
        lamp_tbl[3] = 7'h44;
        rstn       = 1'b0;
        traffic_B  = 1'b1;
        timer_done = 1'b1;
        #2;

        dstep("rst0", 0, 1, 1, 7'h18);
        dstep("rst1", 0, 1, 1, 7'h18);

        dstep("garb_h0", 1, 0, 0, 7'h18);
        dstep("garb_h1", 1, 0, 1, 7'h18);
        dstep("garb_h2", 1, 0, 0, 7'h18);
        dstep("aarb_in", 1, 1, 0, 7'h29);
        dstep("aarb_1", 1, 1, 0, 7'h28);
        dstep("aarb_tb0", 1, 0, 0, 7'h28);
        dstep("aarb_tb1", 1, 1, 0, 7'h28);
        dstep("ragb_in", 1, 1, 1, 7'h42);

        dstep("ragb_h0", 1, 1, 1, 7'h42);
        dstep("ragb_h1", 1, 1, 0, 7'h42);
        dstep("ragb_h2", 1, 1, 1, 7'h42);
        dstep("raab_in", 1, 0, 0, 7'h45);
        dstep("raab_h0", 1, 0, 0, 7'h44);
        dstep("raab_h1", 1, 1, 0, 7'h44);
        dstep("raab_h2", 1, 0, 0, 7'h44);
        dstep("garb_ret", 1, 0, 1, 7'h18);

        // Done held high across amber entry: amber lasts two cycles.
        dstep("stale_a0", 1, 1, 1, 7'h29);
        dstep("stale_a1", 1, 1, 1, 7'h28);
        dstep("stale_a2", 1, 1, 1, 7'h42);
        dstep("stale_b0", 1, 0, 1, 7'h45);
        dstep("stale_b1", 1, 0, 1, 7'h44);
        dstep("stale_b2", 1, 0, 1, 7'h18);

        // Reset during an amber entry cycle.
        dstep("mid_in", 1, 1, 0, 7'h29);
        dstep("mid_rst", 0, 1, 1, 7'h18);
        dstep("mid_res0", 1, 0, 0, 7'h18);
        dstep("mid_res1", 1, 1, 0, 7'h29);

        for (int i = 0; i < 600; i++) begin
            logic r;
            logic tb_in;
            logic td;
            r     = ($urandom_range(99) >= 3);
            tb_in = ($urandom_range(99) < 45);
            td    = ($urandom_range(99) < 40);
            step(r, tb_in, td);
            check("rand", traffic_out, model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
